// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : operand_stage
//  Brief    : RV32I operand-fetch stage. Reads the 31-entry register file
//             (with writeback bypass), decodes OP / OP-IMM / LUI / AUIPC into
//             an ALU operand bundle and holds it in a single-entry output
//             register behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    // Supported major opcodes
    localparam logic [6:0] c_op_reg   = 7'b0110011;
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;

    // Output-register occupancy
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        w_in_ready;
    logic        w_capture;

    // x1..x31; x0 has no storage and always reads as zero
    logic [31:0] r_regs [1:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_legal;
    logic        w_reg_write;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_illegal;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: a capture always fills; a consume without capture empties
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_capture) begin
                    w_state_next = c_st_full;
                end
            end
            default: begin
                if (out_ready && !w_capture) begin
                    w_state_next = c_st_empty;
                end
            end
        endcase
    end

    // Handshake outputs; ready never looks at in_valid
    always_comb begin
        out_valid  = (r_state == c_st_full);
        w_in_ready = (r_state == c_st_empty) || out_ready;
        w_capture  = in_valid && w_in_ready;
    end

    assign in_ready = w_in_ready;

    // Register file write port; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Source operand read with same-cycle writeback bypass
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0) begin
            w_rs1_val = (wb_en && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            w_rs2_val = (wb_en && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];
        end
    end

    // Instruction decode into the ALU operand bundle
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_f3    = '0;
        w_f7    = '0;
        w_legal = 1'b1;
        case (w_opcode)
            c_op_reg: begin
                w_a  = w_rs1_val;
                w_b  = w_rs2_val;
                w_f3 = instr[14:12];
                w_f7 = instr[31:25];
            end
            c_op_imm: begin
                w_a  = w_rs1_val;
                w_b  = {{20{instr[31]}}, instr[31:20]};
                w_f3 = instr[14:12];
                // Only shifts carry a funct7; ADDI/XORI etc. must not look like SUB/SRA
                if ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101)) begin
                    w_f7 = instr[31:25];
                end
            end
            c_op_lui: begin
                w_b = {instr[31:12], 12'b0};
            end
            c_op_auipc: begin
                w_a = pc;
                w_b = {instr[31:12], 12'b0};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        w_reg_write = w_legal && (w_rd != 5'd0);
    end

    // Output bundle register; loads only on capture, otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_capture) begin
            r_alu_a     <= w_a;
            r_alu_b     <= w_b;
            r_funct3    <= w_f3;
            r_funct7    <= w_f7;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_illegal   <= !w_legal;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_stage
//  Brief    : Self-checking bench for operand_stage. Table of instructions
//             with expected bundles plus hand-written bypass, stall and
//             reset sequences; expected bundles flow through a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } bundle_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        bundle_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int          checks   = 0;
    int          failures = 0;
    bundle_t     sb[$];
    bit          m_valid  = 1'b0;
    vec_t        tbl[9];
    bundle_t     dummy;

    operand_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .reg_write (reg_write),
        .illegal   (illegal),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] r, input logic rw, input logic ill);
        bundle_t t;
        t.a = a; t.b = b; t.f3 = f3; t.f7 = f7; t.rd = r; t.rw = rw; t.ill = ill;
        return t;
    endfunction

    task automatic check_out();
        bundle_t e;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid && sb.size() != 0) begin
            e = sb[0];
            chk("alu_a",     alu_a, e.a);
            chk("alu_b",     alu_b, e.b);
            chk("funct3",    {29'b0, funct3}, {29'b0, e.f3});
            chk("funct7",    {25'b0, funct7}, {25'b0, e.f7});
            chk("rd",        {27'b0, rd}, {27'b0, e.rd});
            chk("reg_write", {31'b0, reg_write}, {31'b0, e.rw});
            chk("illegal",   {31'b0, illegal}, {31'b0, e.ill});
        end
    endtask

    // One clock cycle; entered and left at posedge+1
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd, input bundle_t e);
        logic exp_rdy;
        in_valid = iv; instr = ins; pc = p; out_ready = ordy;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        @(posedge clk);
        if (m_valid && ordy) void'(sb.pop_front());
        if (iv && exp_rdy) sb.push_back(e);
        m_valid = (sb.size() != 0);
        #1;
        check_out();
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, r, d, dummy);
    endtask

    // Reset cycle with arbitrary competing traffic; reset must win
    task automatic rst_cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                           input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        rst = 1'b1; in_valid = iv; instr = ins; pc = 32'h0; out_ready = ordy;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        @(posedge clk);
        sb.delete();
        m_valid = 1'b0;
        #1;
        rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_fields", {16'b0, funct3, funct7, rd, reg_write}, 32'h0);
        chk("rst_illegal", {31'b0, illegal}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    endtask

    initial begin
        dummy = mk(32'h0, 32'h0, 3'd0, 7'd0, 5'd0, 1'b0, 1'b0);
        // instr, pc, {a, b, f3, f7, rd, reg_write, illegal} with x1=FFFFFFFF, x5=7, x6=3
        tbl[0] = '{32'h006283B3, 32'h0,    mk(32'd7,        32'd3,        3'd0, 7'h00, 5'd7,  1'b1, 1'b0)}; // ADD x7,x5,x6
        tbl[1] = '{32'hFFF00093, 32'h0,    mk(32'h0,        32'hFFFFFFFF, 3'd0, 7'h00, 5'd1,  1'b1, 1'b0)}; // ADDI x1,x0,-1
        tbl[2] = '{32'h4040D113, 32'h0,    mk(32'hFFFFFFFF, 32'h00000404, 3'd5, 7'h20, 5'd2,  1'b1, 1'b0)}; // SRAI x2,x1,4
        tbl[3] = '{32'h12345197, 32'h1000, mk(32'h00001000, 32'h12345000, 3'd0, 7'h00, 5'd3,  1'b1, 1'b0)}; // AUIPC x3
        tbl[4] = '{32'h123451B7, 32'h1004, mk(32'h0,        32'h12345000, 3'd0, 7'h00, 5'd3,  1'b1, 1'b0)}; // LUI x3
        tbl[5] = '{32'h00628033, 32'h0,    mk(32'd7,        32'd3,        3'd0, 7'h00, 5'd0,  1'b0, 1'b0)}; // ADD x0,x5,x6
        tbl[6] = '{32'h80034493, 32'h0,    mk(32'd3,        32'hFFFFF800, 3'd4, 7'h00, 5'd9,  1'b1, 1'b0)}; // XORI x9,x6,-2048
        tbl[7] = '{32'h0062E533, 32'h0,    mk(32'd7,        32'd3,        3'd6, 7'h00, 5'd10, 1'b1, 1'b0)}; // OR x10,x5,x6
        tbl[8] = '{32'h0000007F, 32'h0,    mk(32'h0,        32'h0,        3'd0, 7'h00, 5'd0,  1'b0, 1'b1)}; // opcode 0x7F

        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        @(posedge clk);
        #1;
        rst_cyc(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

        wb(5'd5, 32'h00000007);
        wb(5'd6, 32'h00000003);
        wb(5'd1, 32'hFFFFFFFF);

        // Back-to-back table vectors with downstream always ready
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, tbl[i].instr, tbl[i].pc, 1'b1, 1'b0, 5'd0, 32'h0, tbl[i].exp);
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, dummy);

        // Bypass: SUB x8,x5,x5 while x5 is being written
        cyc(1'b1, 32'h40528433, 32'h0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF,
            mk(32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 7'h20, 5'd8, 1'b1, 1'b0));
        // Write to x0 alongside ADD x11,x0,x0: no bypass, no storage
        cyc(1'b1, 32'h000005B3, 32'h0, 1'b1, 1'b1, 5'd0, 32'h12345678,
            mk(32'h0, 32'h0, 3'd0, 7'h00, 5'd11, 1'b1, 1'b0));
        // ADD x12,x5,x0: x5 kept the bypassed write, x0 still zero
        cyc(1'b1, 32'h00028633, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'hDEADBEEF, 32'h0, 3'd0, 7'h00, 5'd12, 1'b1, 1'b0));

        // Stall: hold 3 cycles with pending input and source writes
        cyc(1'b1, 32'h006283B3, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'hDEADBEEF, 32'd3, 3'd0, 7'h00, 5'd7, 1'b1, 1'b0));
        cyc(1'b1, 32'h006286B3, 32'h0, 1'b0, 1'b1, 5'd5, 32'h11111111, dummy);
        cyc(1'b1, 32'h006286B3, 32'h0, 1'b0, 1'b1, 5'd6, 32'h22222222, dummy);
        cyc(1'b1, 32'h006286B3, 32'h0, 1'b0, 1'b1, 5'd5, 32'h55555555, dummy);
        // Release: consume + capture in the same cycle, then another
        cyc(1'b1, 32'h006286B3, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'h55555555, 32'h22222222, 3'd0, 7'h00, 5'd13, 1'b1, 1'b0));
        cyc(1'b1, 32'h00530733, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'h22222222, 32'h55555555, 3'd0, 7'h00, 5'd14, 1'b1, 1'b0));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, dummy);

        // Illegal opcode held in a stall, then reset mid-stall
        cyc(1'b1, 32'h0000007F, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'h0, 32'h0, 3'd0, 7'h00, 5'd0, 1'b0, 1'b1));
        cyc(1'b1, 32'h006283B3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, dummy);
        rst_cyc(1'b1, 32'h006283B3, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D);
        // Registers read zero after reset, including x9 written during it
        cyc(1'b1, 32'h006287B3, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'h0, 32'h0, 3'd0, 7'h00, 5'd15, 1'b1, 1'b0));
        cyc(1'b1, 32'h00048833, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            mk(32'h0, 32'h0, 3'd0, 7'h00, 5'd16, 1'b1, 1'b0));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, dummy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameters: none; all widths fixed (RV32I, XLEN=32, 32 architectural registers).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream presents instr/pc this cycle.
REQ-006 in_ready  out  1  stage accepts an instruction this cycle.
REQ-007 instr  in  32  RV32I instruction word.
REQ-008 pc  in  32  address of instr.
REQ-009 out_valid  out  1  ALU operand bundle held in output register.
REQ-010 out_ready  in  1  downstream (ALU/execute) consumes the bundle this cycle.
REQ-011 alu_a, alu_b  out  32 each  ALU operands A and B.
REQ-012 funct3  out  3; funct7  out  7  ALU operation select.
REQ-013 rd  out  5; reg_write  out  1  destination and write intent.
REQ-014 illegal  out  1  captured instruction has unsupported opcode.
REQ-015 wb_en  in  1; wb_rd  in  5; wb_data  in  32  register-file write port from writeback.

Function
REQ-016 Register file SHALL hold 31 writable 32-bit registers; x0 reads 0 always; writes to x0 ignored.
REQ-017 wb_en=1 with wb_rd!=0 SHALL write wb_data at the clock edge, independent of handshake state.
REQ-018 in_ready SHALL equal (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-019 Capture (in_valid && in_ready) SHALL load the output register at the edge; out_valid=1 next cycle; latency 1 cycle.
REQ-020 out_valid SHALL clear when out_ready=1 and no capture occurs that cycle; simultaneous consume+capture keeps out_valid=1 with new bundle (full throughput).
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold stable, including across register-file writes.
REQ-022 Operand read SHALL bypass: if wb_en=1, wb_rd!=0 and wb_rd==rs1 (rs2) in the capture cycle, captured value is wb_data.
REQ-023 OP (0110011): alu_a=rs1, alu_b=rs2, funct3=instr[14:12], funct7=instr[31:25], rd=instr[11:7], reg_write=1.
REQ-024 OP-IMM (0010011): alu_a=rs1, alu_b=sign-extended instr[31:20], funct3=instr[14:12]; funct7=instr[31:25] when funct3 is 001 or 101, else 0 (ADDI never becomes SUB); reg_write=1.
REQ-025 LUI (0110111): alu_a=0, alu_b={instr[31:12],12'b0}, funct3=0, funct7=0, reg_write=1.
REQ-026 AUIPC (0010111): alu_a=pc, alu_b={instr[31:12],12'b0}, funct3=0, funct7=0, reg_write=1.
REQ-027 Any other opcode: illegal=1, reg_write=0, alu_a=alu_b=0, funct3=0, funct7=0; bundle still handshaken normally.
REQ-028 rd==0 SHALL force reg_write=0.
REQ-029 No internal FSM beyond the single-entry valid bit; states EMPTY (out_valid=0) and FULL (out_valid=1), transitions per REQ-019/020.

Reset
REQ-030 rst=1 at an edge SHALL clear out_valid, alu_a, alu_b, funct3, funct7, rd, reg_write, illegal and all 31 registers to 0.
REQ-031 rst SHALL take priority over capture and writeback in the same cycle; in_ready=1 the cycle after reset release.
REQ-032 Reset mid-stall SHALL discard the held bundle without an out_valid pulse.

Verification
REQ-033 wb x5=0x0000_0007, x6=0x0000_0003; capture ADD x7,x5,x6 -> next cycle out_valid=1, alu_a=7, alu_b=3, funct3=0, funct7=0, rd=7, reg_write=1.
REQ-034 Capture ADDI x1,x0,-1 (0xFFF00093) -> alu_a=0, alu_b=0xFFFF_FFFF, funct7=0; SRAI x2,x1,4 (0x4040D113) -> funct3=5, funct7=0x20, alu_b=0x0000_0404.
REQ-035 Capture AUIPC x3,0x12345 at pc=0x0000_1000 -> alu_a=0x0000_1000, alu_b=0x1234_5000; LUI same imm -> alu_a=0.
REQ-036 Same cycle wb_en=1, wb_rd=5, wb_data=0xDEAD_BEEF and capture SUB x8,x5,x5 -> alu_a=alu_b=0xDEAD_BEEF, funct7=0x20; wb to x0 then read x0 -> 0.
REQ-037 Hold out_ready=0 for 3 cycles with in_valid=1 and writes to source regs -> in_ready=0, outputs unchanged; raise out_ready with in_valid=1 -> back-to-back bundles, no bubble, no loss.
REQ-038 Opcode 0x7F captured -> illegal=1, reg_write=0; rst asserted during stall -> next cycle out_valid=0, all registers read 0.
